gcm_tagmask_mc: RTL and testbench
=================================

Name: gcm_tagmask_mc

Overview:
- Multi-channel successor of the single-context GCM tag-mask unit.
- Holds NUM_CH independent key/IV contexts and computes mask = AES_enc(K_ch, IV_ch || CTR_INIT) for each channel on request.
- Drives one external shared AES core through a req/gnt interface, serving channels round-robin.
- Skips key expansion when the requested channel's key is already loaded in the core.

Parameters:
- NUM_CH, 4: number of channel contexts (2..16).
- CH_W, $clog2(NUM_CH): channel index width.
- CTR_INIT, 32'h00000001: counter word appended to the 96-bit IV to form J0.
- KEY_CACHE, 1: 1 = skip aes_init when the loaded key is still valid for the channel; 0 = always re-init.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_ch  in  CH_W  channel addressed by key_we / iv_we.
- key_in  in  256  key; upper 128 bits are forced to zero when aes256_en=0.
- key_we  in  1  write key_in/aes256_en into the cfg_ch context.
- aes256_en  in  1  key length of the write.
- iv_in  in  96  IV.
- iv_we  in  1  write iv_in into the cfg_ch context.
- start  in  NUM_CH  per-channel mask request pulses.
- mask_out  out  128  computed mask.
- mask_ch  out  CH_W  channel of mask_out.
- mask_valid  out  1  one-cycle pulse; mask_out and mask_ch are valid.
- pending  out  NUM_CH  per-channel request outstanding (includes the channel in service).
- busy  out  1  state != IDLE or any pending bit set.
- aes_req  out  1  shared-core request.
- aes_gnt  in  1  shared-core grant.
- aes_init  out  1  key-expansion strobe.
- aes_next  out  1  encrypt strobe.
- aes_key  out  256  key to core.
- aes_keylen  out  1  key length to core.
- aes_block  out  128  plaintext block to core.
- aes_ready  in  1  core ready.
- aes_result  in  128  core result.
- aes_result_valid  in  1  core result valid.

Behaviour:
- Reset values (reset is synchronous, active-high):
  - All outputs are 0.
  - All contexts (key, keylen, iv) are zeroed.
  - pending = 0, rr_ptr = 0, loaded_valid = 0, state = IDLE.
  - Reset asserted mid-operation aborts the job; no mask_valid is produced.
- Context writes:
  - Take effect at the clock edge.
  - key_we and iv_we may be asserted together.
  - A key_we to channel c while loaded_valid && loaded_ch == c clears loaded_valid. This applies even while c is in service.
- Pending:
  - pending[i] is set by start[i] and cleared when channel i is snapshotted.
  - Repeated starts on a channel that is already pending coalesce into one job.
  - A start on the channel currently in service sets pending again, so the channel is serviced a second time later.
- aes_req = (state != IDLE) | (|pending).
- FSM state IDLE:
  - If |pending and aes_gnt: select channel s, the first pending channel at or after rr_ptr (wrapping).
  - Snapshot key, keylen and block = {iv_s, CTR_INIT} into active registers.
  - Clear pending[s].
  - Go to ISSUE_NEXT if KEY_CACHE && loaded_valid && loaded_ch == s; otherwise go to KEY_INIT.
  - If a write and a start hit the same channel in the same cycle, the write is applied first, so the job uses the new data.
- FSM state KEY_INIT:
  - aes_init = 1 for one cycle.
  - Set loaded_ch = s, loaded_valid = 1, unless a key_we to s occurs in this cycle.
  - Go to WAIT_INIT.
- FSM state WAIT_INIT: wait for aes_ready, then go to ISSUE_NEXT.
- FSM state ISSUE_NEXT: aes_next = 1 for one cycle, then go to WAIT_RES.
- FSM state WAIT_RES:
  - On aes_result_valid: register mask_out = aes_result and mask_ch = s; pulse mask_valid in the next cycle.
  - Set rr_ptr = (s+1) mod NUM_CH and go to IDLE.
- aes_key, aes_keylen and aes_block are driven from the active snapshot registers and are stable for the whole job. Context writes during a job do not affect it.
- aes_gnt is sampled only in IDLE. The arbiter holds the grant while aes_req is high.
- Latency from grant to mask_valid:
  - Cache hit: 3 + core encrypt latency.
  - Cache miss: additionally adds 2 + key-expansion latency.
- Starvation-free: a pending channel is served within NUM_CH jobs.

Test Plan:
- Ch0: 128-bit key = 0, iv = 0, start[0]. Required: mask_out = 58e2fccefa7e3061367f1d57a4e7455a, mask_ch = 0, exactly one aes_init.
- Ch1: 256-bit key = 0, iv = 0, start[1]. Required: mask_out = 530f8afbc74536b9a963b4f1c4cb738b, mask_ch = 1.
- Repeat start[1] with no key write. Required: no aes_init pulse and the same mask; a key_we to ch1 followed by start forces aes_init.
- start = 4'b1111 in one cycle, rr_ptr = 0. Required: masks in order ch0, ch1, ch2, ch3; a start[0] asserted during ch0 service results in ch0 being served again after ch3.
- iv_we to ch2 while ch2 is in WAIT_RES. Required: the current mask uses the old IV; the next start[2] uses the new IV. aes_gnt held low: no aes_init or aes_next, aes_req = 1.
- rst pulse during WAIT_RES. Required: no mask_valid; all outputs 0 the next cycle; the next start re-inits the key.

Source files
------------

// File: rtl/gcm_tagmask_mc.sv
// -----------------------------------------------------------------------------
// gcm_tagmask_mc
//
// Multi-channel GCM tag-mask generator. The block holds NUM_CH key/IV
// contexts. For each requested channel it computes
//     mask = AES_enc(K_ch, IV_ch || CTR_INIT)
// on one external AES core that is shared with other users. Channels are
// served round-robin. Key expansion is skipped when the core still holds the
// requested channel's key.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cfg_ch              channel addressed by key_we / iv_we
//   key_in, aes256_en   key and key length (upper 128 bits zeroed for AES-128)
//   key_we, iv_we       context write strobes (may be asserted together)
//   iv_in               96-bit IV
//   start               per-channel mask request pulses
//   mask_out, mask_ch   result and its channel, valid while mask_valid = 1
//   mask_valid          one-cycle result strobe
//   pending             per-channel request outstanding
//   busy                job in flight or any request pending
//   aes_req / aes_gnt   shared-core arbitration (grant sampled in IDLE only)
//   aes_init, aes_next  core key-expansion / encrypt strobes
//   aes_key, aes_keylen, aes_block  job operands, stable for the whole job
//   aes_ready, aes_result, aes_result_valid  core status and result
// -----------------------------------------------------------------------------
module gcm_tagmask_mc #(
    parameter int          NUM_CH    = 4,
    parameter int          CH_W      = $clog2(NUM_CH),
    parameter logic [31:0] CTR_INIT  = 32'h0000_0001,
    parameter bit          KEY_CACHE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [255:0]      key_in,
    input  logic              key_we,
    input  logic              aes256_en,
    input  logic [95:0]       iv_in,
    input  logic              iv_we,
    input  logic [NUM_CH-1:0] start,
    output logic [127:0]      mask_out,
    output logic [CH_W-1:0]   mask_ch,
    output logic              mask_valid,
    output logic [NUM_CH-1:0] pending,
    output logic              busy,
    output logic              aes_req,
    input  logic              aes_gnt,
    output logic              aes_init,
    output logic              aes_next,
    output logic [255:0]      aes_key,
    output logic              aes_keylen,
    output logic [127:0]      aes_block,
    input  logic              aes_ready,
    input  logic [127:0]      aes_result,
    input  logic              aes_result_valid
);

    typedef enum logic [2:0] {
        IDLE,
        KEY_INIT,
        WAIT_INIT,
        ISSUE_NEXT,
        WAIT_RES
    } state_t;

    // Per-channel contexts
    logic [255:0] ctx_key_q [NUM_CH];
    logic [255:0] ctx_key_d [NUM_CH];
    logic         ctx_len_q [NUM_CH];
    logic         ctx_len_d [NUM_CH];
    logic [95:0]  ctx_iv_q  [NUM_CH];
    logic [95:0]  ctx_iv_d  [NUM_CH];

    // Job state
    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              loaded_valid_q, loaded_valid_d;
    logic [CH_W-1:0]   loaded_ch_q, loaded_ch_d;
    logic [CH_W-1:0]   act_ch_q, act_ch_d;
    logic [255:0]      act_key_q, act_key_d;
    logic              act_len_q, act_len_d;
    logic [127:0]      act_block_q, act_block_d;
    logic [127:0]      mask_out_q, mask_out_d;
    logic [CH_W-1:0]   mask_ch_q, mask_ch_d;
    logic              mask_valid_q, mask_valid_d;

    logic              cfg_ok;
    logic [255:0]      key_eff;
    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic              key_hit;

    assign cfg_ok  = (int'(cfg_ch) < NUM_CH);
    assign key_eff = aes256_en ? key_in : {128'b0, key_in[127:0]};

    // Context write path. The snapshot reads the *_d view so a write in the
    // same cycle as the snapshot is seen by the job.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        ctx_key_d = ctx_key_q;
        ctx_len_d = ctx_len_q;
        ctx_iv_d  = ctx_iv_q;
        if (key_we && cfg_ok) begin
            ctx_key_d[cfg_ch] = key_eff;
            ctx_len_d[cfg_ch] = aes256_en;
        end
        if (iv_we && cfg_ok) begin
            ctx_iv_d[cfg_ch] = iv_in;
        end
    end

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!sel_found && pending_q[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    // A key rewrite of the selected channel in the snapshot cycle makes the
    // core's copy stale, so it cannot count as a hit.
    assign key_hit = KEY_CACHE && loaded_valid_q && (loaded_ch_q == sel_ch) &&
                     !(key_we && cfg_ch == sel_ch);

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | start;
        rr_ptr_d       = rr_ptr_q;
        loaded_valid_d = loaded_valid_q;
        loaded_ch_d    = loaded_ch_q;
        act_ch_d       = act_ch_q;
        act_key_d      = act_key_q;
        act_len_d      = act_len_q;
        act_block_d    = act_block_q;
        mask_out_d     = mask_out_q;
        mask_ch_d      = mask_ch_q;
        mask_valid_d   = 1'b0;
        aes_init       = 1'b0;
        aes_next       = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found && aes_gnt) begin
                    act_ch_d    = sel_ch;
                    act_key_d   = ctx_key_d[sel_ch];
                    act_len_d   = ctx_len_d[sel_ch];
                    act_block_d = {ctx_iv_d[sel_ch], CTR_INIT};
                    // A start arriving in the snapshot cycle re-queues the channel.
                    pending_d[sel_ch] = start[sel_ch];
                    state_d = key_hit ? ISSUE_NEXT : KEY_INIT;
                end
            end
            KEY_INIT: begin
                aes_init       = 1'b1;
                loaded_ch_d    = act_ch_q;
                loaded_valid_d = 1'b1;
                state_d        = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (aes_ready) begin
                    state_d = ISSUE_NEXT;
                end
            end
            ISSUE_NEXT: begin
                aes_next = 1'b1;
                state_d  = WAIT_RES;
            end
            WAIT_RES: begin
                if (aes_result_valid) begin
                    mask_out_d   = aes_result;
                    mask_ch_d    = act_ch_q;
                    mask_valid_d = 1'b1;
                    rr_ptr_d     = CH_W'((int'(act_ch_q) + 1) % NUM_CH);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A key write to the loaded channel invalidates the core's copy. This
        // also overrides the KEY_INIT load when the write targets that channel.
        if (key_we && loaded_valid_d && loaded_ch_d == cfg_ch) begin
            loaded_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // pre-edge value of the others regardless of statement order.
        if (rst) begin
            // NOTE: the context arrays are reset explicitly. Zeroed contexts are
            // a visible requirement, so reset cannot be left to power-up values.
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_key_q[i] <= '0;
                ctx_len_q[i] <= 1'b0;
                ctx_iv_q[i]  <= '0;
            end
            state_q        <= IDLE;
            pending_q      <= '0;
            rr_ptr_q       <= '0;
            loaded_valid_q <= 1'b0;
            loaded_ch_q    <= '0;
            act_ch_q       <= '0;
            act_key_q      <= '0;
            act_len_q      <= 1'b0;
            act_block_q    <= '0;
            mask_out_q     <= '0;
            mask_ch_q      <= '0;
            mask_valid_q   <= 1'b0;
        end else begin
            ctx_key_q      <= ctx_key_d;
            ctx_len_q      <= ctx_len_d;
            ctx_iv_q       <= ctx_iv_d;
            state_q        <= state_d;
            pending_q      <= pending_d;
            rr_ptr_q       <= rr_ptr_d;
            loaded_valid_q <= loaded_valid_d;
            loaded_ch_q    <= loaded_ch_d;
            act_ch_q       <= act_ch_d;
            act_key_q      <= act_key_d;
            act_len_q      <= act_len_d;
            act_block_q    <= act_block_d;
            mask_out_q     <= mask_out_d;
            mask_ch_q      <= mask_ch_d;
            mask_valid_q   <= mask_valid_d;
        end
    end

    assign mask_out   = mask_out_q;
    assign mask_ch    = mask_ch_q;
    assign mask_valid = mask_valid_q;
    assign pending    = pending_q;
    assign aes_req    = (state_q != IDLE) || (|pending_q);
    assign busy       = aes_req;
    assign aes_key    = act_key_q;
    assign aes_keylen = act_len_q;
    assign aes_block  = act_block_q;

endmodule

// File: tb/tb_gcm_tagmask_mc.sv
// -----------------------------------------------------------------------------
// tb_gcm_tagmask_mc
//
// Directed bench for gcm_tagmask_mc with a behavioural shared-core model.
// The core model returns the known AES results for the two all-zero-key
// vectors. For every other key it returns a keyed mixing function. The core
// latches its key on aes_init, so a skipped or missing key expansion yields a
// wrong mask.
// -----------------------------------------------------------------------------
module tb_gcm_tagmask_mc;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int INIT_LAT = 4;
    localparam int ENC_LAT  = 6;

    localparam logic [127:0] MASK_Z128 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] MASK_Z256 = 128'h530f8afbc74536b9a963b4f1c4cb738b;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH_W-1:0]   cfg_ch;
    logic [255:0]      key_in;
    logic              key_we;
    logic              aes256_en;
    logic [95:0]       iv_in;
    logic              iv_we;
    logic [NUM_CH-1:0] start;
    logic [127:0]      mask_out;
    logic [CH_W-1:0]   mask_ch;
    logic              mask_valid;
    logic [NUM_CH-1:0] pending;
    logic              busy;
    logic              aes_req;
    logic              aes_gnt;
    logic              aes_init;
    logic              aes_next;
    logic [255:0]      aes_key;
    logic              aes_keylen;
    logic [127:0]      aes_block;
    logic              aes_ready = 1'b1;
    logic [127:0]      aes_result = '0;
    logic              aes_result_valid = 1'b0;

    gcm_tagmask_mc #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CTR_INIT(32'h0000_0001), .KEY_CACHE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_ch(cfg_ch), .key_in(key_in), .key_we(key_we),
        .aes256_en(aes256_en), .iv_in(iv_in), .iv_we(iv_we), .start(start),
        .mask_out(mask_out), .mask_ch(mask_ch), .mask_valid(mask_valid),
        .pending(pending), .busy(busy), .aes_req(aes_req), .aes_gnt(aes_gnt),
        .aes_init(aes_init), .aes_next(aes_next), .aes_key(aes_key),
        .aes_keylen(aes_keylen), .aes_block(aes_block), .aes_ready(aes_ready),
        .aes_result(aes_result), .aes_result_valid(aes_result_valid)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_init   = 0;
    int n_next   = 0;

    // Shared-core model state
    logic [255:0] core_key = '0;
    logic         core_len = 1'b0;
    logic [127:0] core_blk = '0;
    int           lat_cnt  = 0;
    bit           enc_run  = 1'b0;
    logic [CH_W+127:0] mask_q [$];

    function automatic logic [127:0] aes_model(input logic [255:0] k, input logic len,
                                               input logic [127:0] blk);
        if (!len && k == '0 && blk == 128'h1) return MASK_Z128;
        if (len && k == '0 && blk == 128'h1) return MASK_Z256;
        return k[255:128] ^ {k[126:0], k[127]} ^ {blk[63:0], blk[127:64]} ^
               {128{len}} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    function automatic logic [127:0] exp_mask(input logic [255:0] k, input logic len,
                                              input logic [95:0] iv);
        logic [255:0] k_eff;
        k_eff = len ? k : {128'b0, k[127:0]};
        return aes_model(k_eff, len, {iv, 32'h0000_0001});
    endfunction

    // The core and the mask monitor run on the falling edge. DUT strobes are
    // stable then, and the responses are settled before the next rising edge.
    always @(negedge clk) begin
        aes_result_valid = 1'b0;
        if (rst) begin
            aes_ready = 1'b1;
            lat_cnt   = 0;
            enc_run   = 1'b0;
        end else if (aes_init) begin
            core_key  = aes_key;
            core_len  = aes_keylen;
            n_init++;
            aes_ready = 1'b0;
            lat_cnt   = INIT_LAT;
            enc_run   = 1'b0;
        end else if (aes_next) begin
            core_blk  = aes_block;
            n_next++;
            aes_ready = 1'b0;
            lat_cnt   = ENC_LAT;
            enc_run   = 1'b1;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                aes_ready = 1'b1;
                if (enc_run) begin
                    aes_result       = aes_model(core_key, core_len, core_blk);
                    aes_result_valid = 1'b1;
                    enc_run          = 1'b0;
                end
            end
        end
        if (mask_valid) mask_q.push_back({mask_ch, mask_out});
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_ctx(input int ch, input logic [255:0] k, input logic len,
                             input logic [95:0] iv);
        cfg_ch = CH_W'(ch); key_in = k; aes256_en = len; iv_in = iv;
        key_we = 1'b1; iv_we = 1'b1;
        tick(1);
        key_we = 1'b0; iv_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] s);
        start = s;
        tick(1);
        start = '0;
    endtask

    task automatic wait_mask(input string tag, output logic [127:0] m, output logic [CH_W-1:0] c);
        int cyc = 0;
        while (mask_q.size() == 0 && cyc < 300) begin
            tick(1);
            cyc++;
        end
        if (mask_q.size() == 0) begin
            check({tag, "_timeout"}, 256'd0, 256'd1);
            m = '0;
            c = '0;
        end else begin
            {c, m} = mask_q.pop_front();
        end
    endtask

    task automatic wait_next(input string tag, input int base);
        int cyc = 0;
        while (n_next == base && cyc < 300) begin
            tick(1);
            cyc++;
        end
        if (n_next == base) check({tag, "_next_timeout"}, 256'd0, 256'd1);
    endtask

    task automatic job(input int ch, input logic [127:0] exp_m, input int init_delta,
                       input string tag);
        logic [127:0]    m;
        logic [CH_W-1:0] c;
        int              base;
        base = n_init;
        pulse_start(NUM_CH'(1) << ch);
        wait_mask(tag, m, c);
        check({tag, "_mask"}, 256'(m), 256'(exp_m));
        check({tag, "_ch"}, 256'(c), 256'(ch));
        check({tag, "_inits"}, 256'(n_init - base), 256'(init_delta));
    endtask

    localparam logic [255:0] K2  = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
    localparam logic [95:0]  I2  = 96'hcafebabefacedbaddecaf888;
    localparam logic [95:0]  I2B = 96'h1122334455667788_99aabbcc;
    localparam logic [255:0] K3  = 256'hffffffff00000000ffffffff00000000_2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [95:0]  I3  = 96'h000000000000000000000042;

    initial begin
        logic [127:0]    m;
        logic [CH_W-1:0] c;
        logic [127:0]    exp_order [5];
        int              bi, bn;

        rst = 1'b1; cfg_ch = '0; key_in = '0; key_we = 1'b0; aes256_en = 1'b0;
        iv_in = '0; iv_we = 1'b0; start = '0; aes_gnt = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_mask_valid", 256'(mask_valid), 256'd0);
        check("rst_mask_out", 256'(mask_out), 256'd0);
        check("rst_aes_req", 256'(aes_req), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_pending", 256'(pending), 256'd0);
        check("rst_aes_init", 256'(aes_init), 256'd0);
        check("rst_aes_key", aes_key, 256'd0);

        aes_gnt = 1'b1;

        // AES-128 zero key; the garbage upper half must be dropped
        write_ctx(0, {128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'h0}, 1'b0, 96'h0);
        job(0, MASK_Z128, 1, "ch0_aes128");

        // AES-256 zero key
        write_ctx(1, 256'h0, 1'b1, 96'h0);
        job(1, MASK_Z256, 1, "ch1_aes256");

        // Cached key, then a rewrite forces re-expansion
        job(1, MASK_Z256, 0, "ch1_cached");
        write_ctx(1, 256'h0, 1'b1, 96'h0);
        job(1, MASK_Z256, 1, "ch1_rekey");

        // ch3 job moves rr_ptr back to 0
        write_ctx(2, K2, 1'b1, I2);
        write_ctx(3, K3, 1'b0, I3);
        job(3, exp_mask(K3, 1'b0, I3), 1, "ch3_single");

        // All four at once, plus a re-request of ch0 while it is in service
        pulse_start(4'b1111);
        check("pending_all", 256'(pending), 256'(4'b1111));
        tick(1);
        check("pending_ch0_taken", 256'(pending), 256'(4'b1110));
        pulse_start(4'b0001);
        check("pending_ch0_requeued", 256'(pending), 256'(4'b1111));
        exp_order[0] = MASK_Z128;
        exp_order[1] = MASK_Z256;
        exp_order[2] = exp_mask(K2, 1'b1, I2);
        exp_order[3] = exp_mask(K3, 1'b0, I3);
        exp_order[4] = MASK_Z128;
        for (int i = 0; i < 5; i++) begin
            wait_mask("rr", m, c);
            check($sformatf("rr%0d_ch", i), 256'(c), 256'(i % NUM_CH));
            check($sformatf("rr%0d_mask", i), 256'(m), 256'(exp_order[i]));
        end

        // IV rewrite during WAIT_RES does not affect the job in flight
        bn = n_next;
        pulse_start(4'b0100);
        wait_next("ch2_iv", bn);
        cfg_ch = 2'd2; iv_in = I2B; iv_we = 1'b1;
        tick(1);
        iv_we = 1'b0;
        wait_mask("ch2_old_iv", m, c);
        check("ch2_old_iv_mask", 256'(m), 256'(exp_mask(K2, 1'b1, I2)));
        check("ch2_old_iv_ch", 256'(c), 256'd2);
        job(2, exp_mask(K2, 1'b1, I2B), 0, "ch2_new_iv");

        // Grant withheld: request raised, core untouched
        aes_gnt = 1'b0;
        bi = n_init;
        bn = n_next;
        pulse_start(4'b1000);
        tick(4);
        check("nognt_aes_req", 256'(aes_req), 256'd1);
        check("nognt_busy", 256'(busy), 256'd1);
        check("nognt_pending", 256'(pending), 256'(4'b1000));
        check("nognt_no_init", 256'(n_init), 256'(bi));
        check("nognt_no_next", 256'(n_next), 256'(bn));
        aes_gnt = 1'b1;
        wait_mask("gnt_late", m, c);
        check("gnt_late_mask", 256'(m), 256'(exp_mask(K3, 1'b0, I3)));
        check("gnt_late_ch", 256'(c), 256'd3);

        // Reset during WAIT_RES aborts the job
        bn = n_next;
        pulse_start(4'b0001);
        wait_next("rst_mid", bn);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_mask_valid", 256'(mask_valid), 256'd0);
        check("midrst_mask_out", 256'(mask_out), 256'd0);
        check("midrst_mask_ch", 256'(mask_ch), 256'd0);
        check("midrst_aes_req", 256'(aes_req), 256'd0);
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_pending", 256'(pending), 256'd0);
        check("midrst_strobes", 256'({aes_init, aes_next}), 256'd0);
        check("midrst_aes_key", aes_key, 256'd0);
        check("midrst_aes_block", 256'(aes_block), 256'd0);
        check("midrst_aes_keylen", 256'(aes_keylen), 256'd0);
        tick(ENC_LAT + 4);
        check("midrst_no_mask", 256'(mask_q.size()), 256'd0);

        // Contexts were zeroed; the core key must be re-expanded
        job(0, MASK_Z128, 1, "post_rst_ch0");
        job(2, MASK_Z128, 1, "post_rst_ch2_cleared");

        tick(3);
        check("no_extra_masks", 256'(mask_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
